axi_mem_responder: RTL
======================

// Module: axi_mem_responder
// PURPOSE
// - AXI responder (slave) memory for the core's external AXI port: accepts AW/W/B write and AR/R read bursts, backs them with a word array.
// - Sits at the far end of the memory arbiter's AXI bus in benches and FPGA builds. It stands in for DRAM.
// - Read and write channels run independently. Each has one outstanding burst.
// PARAMETERS
// - ADDR_WIDTH   26    byte-address width (`ADDR_WIDTH)
// - DATA_WIDTH   32    beat width (`DATA_WIDTH)
// - DEPTH_LOG2   16    log2 of the number of words in the backing store
// - RD_LATENCY   4     cycles between AR accept and first R beat (used only with AXI_MEM_LATENCY_EN)
// PORTS
// - clk         in   1           clock
// - rst         in   1           synchronous reset, active-high
// - AWVALID/AWREADY  in/out 1    write-address handshake
// - AWID, AWLEN in   4,4         write ID; beats-1
// - AWADDR      in   ADDR_WIDTH  write byte address
// - WVALID/WREADY    in/out 1    write-data handshake
// - WLAST, WID  in   1,4         last-beat marker; data ID
// - WDATA       in   DATA_WIDTH  write beat
// - BVALID/BREADY    out/in 1    write-response handshake
// - BID         out  4           = captured AWID
// - ARVALID/ARREADY  in/out 1    read-address handshake
// - ARID, ARLEN in   4,4         read ID; beats-1
// - ARADDR      in   ADDR_WIDTH  read byte address
// - RVALID/RREADY    out/in 1    read-data handshake
// - RLAST, RID  out  1,4         last beat; = captured ARID
// - RDATA       out  DATA_WIDTH  read beat
// - proto_err   out  1           sticky: WLAST/WID mismatch seen
// BEHAVIOUR
// - Reset: all outputs 0, FSMs idle, proto_err=0. Memory array is not cleared.
// - Reset mid-burst aborts the burst. No B/R beat is issued for it.
// - Word index = addr[DEPTH_LOG2+1:2]. Byte offset is ignored. Bursts are INCR.
// - A burst has LEN+1 beats. The index advances +1 per beat and wraps mod 2^DEPTH_LOG2.
// - Write FSM:
//   - W_IDLE: AWREADY=1. On AWVALID, capture AWID/AWLEN/index and go to W_DATA.
//   - W_DATA: WREADY=1. Each WVALID&WREADY beat writes WDATA at the clock edge.
//   - W_DATA: after beat LEN+1, go to W_RESP. The beat counter, not WLAST, ends the burst.
//   - W_RESP: BVALID=1 and held until BREADY. Then go to W_IDLE. AWREADY is 0 outside W_IDLE.
// - proto_err is set in these cases:
//   - WLAST != (beat==LEN) on any accepted beat.
//   - WID != captured AWID on any accepted beat.
// - Read FSM:
//   - R_IDLE: ARREADY=1. On ARVALID, capture ARID/ARLEN/index.
//   - R_IDLE: go to R_WAIT if the latency macro is defined, else to R_BURST.
//   - R_WAIT: count RD_LATENCY-1 cycles, then go to R_BURST.
//   - R_BURST: RVALID=1 with RDATA = mem[index]. RLAST=1 on beat LEN.
//   - R_BURST: RDATA/RLAST/RID are held stable while RVALID & !RREADY. The index advances only on RREADY.
//   - R_BURST: after the RLAST handshake, go to R_IDLE.
// - Minimum latency without the macro:
//   - AR accept at cycle N, first RVALID at N+1.
//   - AW accept at N, WREADY at N+1, BVALID the cycle after the last W beat.
// - Same-cycle read beat and write beat to the same word: R returns the old data. The write lands at the edge.
// - Next AR/AW is accepted no earlier than the cycle after returning to idle. There is no back-to-back overlap.
// CONFIGURATION
// - AXI_MEM_LATENCY_EN defined: the R_WAIT state exists. First R beat at AR-accept + RD_LATENCY cycles (RD_LATENCY>=1).
// - AXI_MEM_LATENCY_EN defined: RD_LATENCY=1 behaves like the macro being undefined.
// - AXI_MEM_LATENCY_EN undefined: no R_WAIT and no counter. First R beat at AR-accept + 1.
// TESTING
// - Reset: rst=1 for 2 cycles -> all outputs 0. After release, AWREADY=ARREADY=1 next cycle.
// - Write then read:
//   - Stimulus: AW(ID=3,LEN=3,ADDR=0x100), W 0xA0..0xA3 with WLAST on the 4th beat.
//   - Response: BVALID with BID=3, proto_err=0.
//   - Then AR(ID=5,LEN=3,ADDR=0x100) -> RDATA 0xA0,0xA1,0xA2,0xA3 with RID=5 and RLAST on the 4th beat.
// - Backpressure:
//   - Stimulus: RREADY toggled 1,0,0,1 during a LEN=1 read.
//   - Response: RDATA/RLAST are stable while stalled, exactly 2 handshakes occur, and BREADY=0 holds BVALID.
// - Wrap:
//   - Stimulus: with DEPTH_LOG2=4, write LEN=1 at ADDR=0x3C.
//   - Response: words 15 and 0 are written. Readback at 0x00 returns the second beat.
// - Protocol error: WLAST asserted on beat 1 of a LEN=2 burst -> proto_err=1 and stays 1. The burst still takes 3 beats.
// - Abort and latency:
//   - Stimulus: rst pulsed mid read burst.
//   - Response: RVALID=0 next cycle and a new AR is accepted.
//   - With AXI_MEM_LATENCY_EN and RD_LATENCY=4: AR accepted at cycle 10 -> first RVALID at cycle 14.

Source files
------------

// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
//
// Purpose
//   AXI responder memory that stands in for DRAM at the far end of the memory
//   arbiter's AXI bus. It accepts AW/W/B write bursts and AR/R read bursts of
//   the INCR type and backs them with a word array. The read channel and the
//   write channel are independent. Each channel holds one outstanding burst.
//
// Configuration macro
//   AXI_MEM_LATENCY_EN : when this macro is defined, an R_WAIT state delays the
//                        first R beat to AR-accept + RD_LATENCY cycles. When it
//                        is undefined, the first R beat comes at AR-accept + 1.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   AWVALID/AWREADY, AWID, AWLEN, AWADDR   write address channel
//   WVALID/WREADY, WLAST, WID, WDATA       write data channel
//   BVALID/BREADY, BID                     write response channel
//   ARVALID/ARREADY, ARID, ARLEN, ARADDR   read address channel
//   RVALID/RREADY, RLAST, RID, RDATA       read data channel
//   proto_err                     sticky flag: WLAST or WID mismatch seen
// ---------------------------------------------------------------------------
module axi_mem_responder #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 16,
    parameter int RD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  proto_err
);

    localparam int Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IdxOne = 1;
    // An illegal latency setting (below 1) keeps the read channel closed
    // instead of producing an undefined wait count.
    localparam logic LatencyCfgOk = (RD_LATENCY >= 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wrState_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
`ifdef AXI_MEM_LATENCY_EN
        R_WAIT  = 2'd1,
`endif
        R_BURST = 2'd2
    } rdState_e;

    logic [DATA_WIDTH-1:0] mem [Depth];

    wrState_e              wrState_q, wrState_d;
    logic [3:0]            wrId_q, wrId_d;
    logic [3:0]            wrLen_q, wrLen_d;
    logic [3:0]            wrBeat_q, wrBeat_d;
    logic [DEPTH_LOG2-1:0] wrIdx_q, wrIdx_d;
    logic                  protoErr_q, protoErr_d;
    logic                  memWe;

    rdState_e              rdState_q, rdState_d;
    logic [3:0]            rdId_q, rdId_d;
    logic [3:0]            rdLen_q, rdLen_d;
    logic [3:0]            rdBeat_q, rdBeat_d;
    logic [DEPTH_LOG2-1:0] rdIdx_q, rdIdx_d;

`ifdef AXI_MEM_LATENCY_EN
    localparam int CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    logic [CntW-1:0]       rdCnt_q, rdCnt_d;
`endif

    logic awFire, wFire, bFire, arFire, rFire;
    logic wrLastBeat, rdLastBeat;

    // Only the word-index bits of the addresses are used. Byte offset and
    // high bits are intentionally ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{AWADDR, ARADDR};

    // Handshake-side outputs are decoded from state and forced low while reset
    // is held, so every output reads 0 during reset.
    assign AWREADY   = !rst && (wrState_q == W_IDLE);
    assign WREADY    = !rst && (wrState_q == W_DATA);
    assign BVALID    = !rst && (wrState_q == W_RESP);
    assign BID       = BVALID ? wrId_q : 4'd0;
    assign ARREADY   = !rst && (rdState_q == R_IDLE) && LatencyCfgOk;
    assign RVALID    = !rst && (rdState_q == R_BURST);
    assign rdLastBeat = (rdBeat_q == rdLen_q);
    assign RLAST     = RVALID && rdLastBeat;
    assign RID       = RVALID ? rdId_q : 4'd0;
    // The combinational array read returns the pre-edge contents. A write to
    // the same word in the same cycle therefore lands only after this beat.
    assign RDATA     = RVALID ? mem[rdIdx_q] : '0;
    assign proto_err = protoErr_q;

    assign awFire = AWVALID && AWREADY;
    assign wFire  = WVALID && WREADY;
    assign bFire  = BVALID && BREADY;
    assign arFire = ARVALID && ARREADY;
    assign rFire  = RVALID && RREADY;
    assign wrLastBeat = (wrBeat_q == wrLen_q);

    // Write channel next-state logic. The beat counter, not WLAST, ends the
    // burst. WLAST and WID are only checked, and any disagreement sets the
    // sticky protocol error flag.
    always_comb begin
        wrState_d  = wrState_q;
        wrId_d     = wrId_q;
        wrLen_d    = wrLen_q;
        wrBeat_d   = wrBeat_q;
        wrIdx_d    = wrIdx_q;
        protoErr_d = protoErr_q;
        memWe      = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                if (awFire) begin
                    wrId_d    = AWID;
                    wrLen_d   = AWLEN;
                    wrBeat_d  = 4'd0;
                    wrIdx_d   = AWADDR[DEPTH_LOG2+1:2];
                    wrState_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wFire) begin
                    memWe = 1'b1;
                    if ((WLAST != wrLastBeat) || (WID != wrId_q)) begin
                        protoErr_d = 1'b1;
                    end
                    if (wrLastBeat) begin
                        wrState_d = W_RESP;
                    end else begin
                        wrBeat_d = wrBeat_q + 4'd1;
                        wrIdx_d  = wrIdx_q + IdxOne;
                    end
                end
            end
            W_RESP: begin
                if (bFire) begin
                    wrState_d = W_IDLE;
                end
            end
            default: begin
                wrState_d = W_IDLE;
            end
        endcase
    end

    // Write channel state register. Reset drops any burst in flight, so no B
    // response is ever issued for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrState_q  <= W_IDLE;
            wrId_q     <= 4'd0;
            wrLen_q    <= 4'd0;
            wrBeat_q   <= 4'd0;
            wrIdx_q    <= '0;
            protoErr_q <= 1'b0;
        end else begin
            wrState_q  <= wrState_d;
            wrId_q     <= wrId_d;
            wrLen_q    <= wrLen_d;
            wrBeat_q   <= wrBeat_d;
            wrIdx_q    <= wrIdx_d;
            protoErr_q <= protoErr_d;
        end
    end

    // Backing store. It is deliberately not cleared by reset. Writes cannot
    // happen during reset because WREADY is held low.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[wrIdx_q] <= WDATA;
        end
    end

    // Read channel next-state logic. The index advances only on an accepted
    // beat, so RDATA/RLAST/RID stay put while the master stalls.
    always_comb begin
        rdState_d = rdState_q;
        rdId_d    = rdId_q;
        rdLen_d   = rdLen_q;
        rdBeat_d  = rdBeat_q;
        rdIdx_d   = rdIdx_q;
`ifdef AXI_MEM_LATENCY_EN
        rdCnt_d   = rdCnt_q;
`endif
        case (rdState_q)
            R_IDLE: begin
                if (arFire) begin
                    rdId_d   = ARID;
                    rdLen_d  = ARLEN;
                    rdBeat_d = 4'd0;
                    rdIdx_d  = ARADDR[DEPTH_LOG2+1:2];
`ifdef AXI_MEM_LATENCY_EN
                    rdCnt_d  = '0;
                    // A latency of 1 needs no wait cycles at all.
                    rdState_d = (RD_LATENCY > 1) ? R_WAIT : R_BURST;
`else
                    rdState_d = R_BURST;
`endif
                end
            end
`ifdef AXI_MEM_LATENCY_EN
            // R_WAIT lasts RD_LATENCY-1 cycles. Together with the accept
            // cycle, this puts the first beat RD_LATENCY cycles after accept.
            R_WAIT: begin
                if (rdCnt_q == CntW'(RD_LATENCY - 2)) begin
                    rdState_d = R_BURST;
                end else begin
                    rdCnt_d = rdCnt_q + CntW'(1);
                end
            end
`endif
            R_BURST: begin
                if (rFire) begin
                    if (rdLastBeat) begin
                        rdState_d = R_IDLE;
                    end else begin
                        rdBeat_d = rdBeat_q + 4'd1;
                        rdIdx_d  = rdIdx_q + IdxOne;
                    end
                end
            end
            default: begin
                rdState_d = R_IDLE;
            end
        endcase
    end

    // Read channel state register. Reset aborts a burst in progress without
    // issuing its remaining beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdState_q <= R_IDLE;
            rdId_q    <= 4'd0;
            rdLen_q   <= 4'd0;
            rdBeat_q  <= 4'd0;
            rdIdx_q   <= '0;
`ifdef AXI_MEM_LATENCY_EN
            rdCnt_q   <= '0;
`endif
        end else begin
            rdState_q <= rdState_d;
            rdId_q    <= rdId_d;
            rdLen_q   <= rdLen_d;
            rdBeat_q  <= rdBeat_d;
            rdIdx_q   <= rdIdx_d;
`ifdef AXI_MEM_LATENCY_EN
            rdCnt_q   <= rdCnt_d;
`endif
        end
    end

endmodule
